// File: rtl/c_readout_buffer.sv
// Result readout buffer: captures a full result matrix in one cycle and
// returns it as 32-bit words, one per read strobe, with a done pulse on the last word.
module c_readout_buffer #(
  parameter int ELEM_W = 16,
  parameter int N_ELEM = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_valid,
  input  logic [ELEM_W*N_ELEM-1:0] res_data,
  output logic                     res_ready,
  input  logic                     rd_en,
  output logic [31:0]              PRDATA,
  output logic                     rd_valid,
  output logic                     read_C_done,
  output logic                     overrun
);
  localparam int TOT_W = ELEM_W * N_ELEM;
  localparam int NW    = (TOT_W + 31) / 32;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [TOT_W-1:0]  cap_q, cap_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic [NW*32-1:0]    cap_pad;
  logic [NW-1:0][31:0] words;
  logic                idx_last;

  // Zero-extend the capture so the top word reads 0 above the last element.
  always_comb begin
    cap_pad              = '0;
    cap_pad[TOT_W-1:0]   = cap_q;
    words                = cap_pad;
  end

  assign idx_last = (idx_q == IW'(NW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cap_q      <= '0;
      prdata_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      prdata_q   <= prdata_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (res_valid) state_d = HOLD;
      HOLD:    if (rd_en && idx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d      = idx_q;
    cap_d      = cap_q;
    prdata_d   = prdata_q;
    rd_valid_d = rd_en;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    if (state_q == IDLE) begin
      if (rd_en) prdata_d = '0;
      if (res_valid) begin
        cap_d = res_data;
        idx_d = '0;
      end
    end else begin
      // A result arriving while a matrix is still held is dropped, even on the last-word beat.
      ovr_d = res_valid;
      if (rd_en) begin
        prdata_d = words[idx_q];
        if (idx_last) begin
          done_d = 1'b1;
          idx_d  = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
    end
  end

  always_comb begin
    res_ready = (state_q == IDLE);
  end

  assign PRDATA      = prdata_q;
  assign rd_valid    = rd_valid_q;
  assign read_C_done = done_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_c_readout_buffer.sv
// Scoreboard bench for c_readout_buffer: an element-level matrix model queues
// expected read beats and overrun pulses; a negedge monitor checks the DUT.
module tb_c_readout_buffer;
  localparam int ELEM_W = 16;
  localparam int N_ELEM = 9;
  localparam int NW     = (ELEM_W * N_ELEM + 31) / 32;

  typedef struct {
    logic [31:0] d;
    bit          done;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     res_valid = 1'b0;
  logic [ELEM_W*N_ELEM-1:0] res_data = '0;
  logic                     res_ready;
  logic                     rd_en = 1'b0;
  logic [31:0]              PRDATA;
  logic                     rd_valid;
  logic                     read_C_done;
  logic                     overrun;

  c_readout_buffer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .rd_en(rd_en), .PRDATA(PRDATA), .rd_valid(rd_valid),
    .read_C_done(read_C_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  beat_t       exp_q[$];
  int          ovr_cnt  = 0;
  bit          m_hold   = 0;
  int          m_ptr    = 0;
  logic [15:0] m_elem[N_ELEM];
  logic [31:0] exp_last = '0;
  bit          mon_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int k);
    logic [31:0] w = '0;
    for (int e = 0; e < N_ELEM; e++)
      if ((e * ELEM_W) / 32 == k) w |= 32'(m_elem[e]) << ((e * ELEM_W) % 32);
    return w;
  endfunction

  // Applied at each rising edge with the inputs the DUT just sampled.
  task automatic model_edge();
    bit    was_hold = m_hold;
    beat_t b;
    if (rst) begin
      m_hold = 0; m_ptr = 0; exp_q.delete(); ovr_cnt = 0; exp_last = '0;
      return;
    end
    if (rd_en) begin
      if (was_hold) begin
        b.d = model_word(m_ptr);
        b.done = (m_ptr == NW - 1);
        if (b.done) begin m_ptr = 0; m_hold = 0; end
        else m_ptr++;
      end else begin
        b.d = '0; b.done = 0;
      end
      exp_q.push_back(b);
    end
    if (res_valid) begin
      if (was_hold) ovr_cnt++;
      else begin
        for (int e = 0; e < N_ELEM; e++) m_elem[e] = res_data[e*ELEM_W +: ELEM_W];
        m_hold = 1; m_ptr = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [ELEM_W*N_ELEM-1:0] d, input bit rd);
    rst = r; res_valid = rv; res_data = d; rd_en = rd;
    @(posedge clk);
    model_edge();
    if (r) mon_en = 1;
    #1;
    rst = 0; res_valid = 0; rd_en = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  function automatic logic [ELEM_W*N_ELEM-1:0] mat(input logic [15:0] base);
    logic [ELEM_W*N_ELEM-1:0] m;
    for (int e = 0; e < N_ELEM; e++) m[e*ELEM_W +: ELEM_W] = base + 16'(e);
    return m;
  endfunction

  function automatic logic [ELEM_W*N_ELEM-1:0] fill(input logic [15:0] v);
    logic [ELEM_W*N_ELEM-1:0] m;
    for (int e = 0; e < N_ELEM; e++) m[e*ELEM_W +: ELEM_W] = v;
    return m;
  endfunction

  // Monitor: outputs registered at a posedge are checked on the following negedge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rd_valid) begin
          if (exp_q.size() == 0) chk("spurious_rd_valid", 32'(rd_valid), 32'd0);
          else begin
            b = exp_q.pop_front();
            chk("prdata", PRDATA, b.d);
            chk("read_C_done", 32'(read_C_done), 32'(b.done));
            exp_last = b.d;
          end
        end else begin
          if (exp_q.size() != 0) begin
            chk("rd_valid_latency", 32'(rd_valid), 32'd1);
            exp_q.delete();
          end
          chk("prdata_hold", PRDATA, exp_last);
          chk("done_idle", 32'(read_C_done), 32'd0);
        end
        if (overrun) begin
          if (ovr_cnt == 0) chk("spurious_overrun", 32'(overrun), 32'd0);
          else ovr_cnt--;
        end else if (ovr_cnt != 0) begin
          chk("overrun_missing", 32'(overrun), 32'd1);
          ovr_cnt = 0;
        end
        chk("res_ready", 32'(res_ready), 32'(!m_hold));
      end
    end
  end

  initial begin
    // Reset held two cycles
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    @(negedge clk);
    chk("reset_res_ready", 32'(res_ready), 32'd1);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_done", 32'(read_C_done), 32'd0);
    @(posedge clk); #1;

    // Capture then 5 back-to-back reads
    step(0, 1, mat(16'h0100), 0);
    for (int i = 0; i < NW; i++) step(0, 0, '0, 1);
    idle(2);

    // Spaced reads
    step(0, 1, mat(16'h0100), 0);
    for (int i = 0; i < NW; i++) begin step(0, 0, '0, 1); idle(2); end

    // Overrun after two reads
    step(0, 1, mat(16'h0100), 0);
    step(0, 0, '0, 1); step(0, 0, '0, 1);
    step(0, 1, fill(16'hFFFF), 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    idle(2);

    // Idle read
    step(0, 0, '0, 1);
    idle(1);

    // Overrun on the last-word beat, result dropped
    step(0, 1, mat(16'h0300), 0);
    for (int i = 0; i < NW - 1; i++) step(0, 0, '0, 1);
    step(0, 1, fill(16'hAAAA), 1);
    idle(1);

    // Capture and read in the same idle cycle
    step(0, 1, mat(16'h0400), 1);
    for (int i = 0; i < NW; i++) step(0, 0, '0, 1);

    // Reset mid-matrix
    step(0, 1, mat(16'h0100), 0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    step(1, 0, '0, 0);
    step(0, 1, mat(16'h0200), 0);
    for (int i = 0; i < NW; i++) step(0, 0, '0, 1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [ELEM_W*N_ELEM-1:0] d;
      for (int e = 0; e < N_ELEM; e++) d[e*ELEM_W +: ELEM_W] = 16'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), d, $urandom_range(0, 1) == 1);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
